// File: rtl/if_id_stage.sv
// IF/ID pipeline register: captures instruction and PC+4, predecodes register fields,
// detects load-use hazards against the load in ID/EX, and counts stall/flush events.
module if_id_stage #(
  parameter int          CNT_W    = 16,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr_in,
  input  logic [31:0]      pc4_in,
  input  logic             hold_in,
  input  logic             redirect,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  output logic [31:0]      instr_out,
  output logic [31:0]      pc4_out,
  output logic             valid_out,
  output logic [5:0]       opcode,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [5:0]       funct,
  output logic [15:0]      imm16,
  output logic             pc_write,
  output logic             id_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc4_q, pc4_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             uses_rt;
  logic             hazard;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign instr_out = instr_q;
  assign pc4_out   = pc4_q;
  assign valid_out = valid_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  assign opcode = instr_q[31:26];
  assign rs     = instr_q[25:21];
  assign rt     = instr_q[20:16];
  assign rd     = instr_q[15:11];
  assign funct  = instr_q[5:0];
  assign imm16  = instr_q[15:0];

  // Only R-type, beq and sw read rt as a source; loads/immediates write it.
  assign uses_rt = (opcode == 6'h00) || (opcode == 6'h04) || (opcode == 6'h2b);

  assign hazard = ex_memread && valid_q && (ex_rt != 5'd0) &&
                  ((ex_rt == rs) || ((ex_rt == rt) && uses_rt));

  assign pc_write  = ~(hazard & ~redirect) & ~(hold_in & ~redirect);
  assign id_bubble = (hazard & ~redirect) | ~valid_q;

  always_comb begin
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (redirect) begin
      instr_d     = NOP_WORD;
      valid_d     = 1'b0;
      pc4_d       = pc4_in;
      flush_cnt_d = sat_inc(flush_cnt_q);
    end else if (hazard) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end else if (!hold_in) begin
      instr_d = instr_in;
      pc4_d   = pc4_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q     <= NOP_WORD;
      pc4_q       <= 32'h0;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule
